layer_output_serializer: RTL and testbench
==========================================

// Module: layer_output_serializer
// PURPOSE
//   Converts the parallel per-neuron results of one network layer (NN values, one
//   independent valid pulse per neuron) into a serial stream of one value per cycle.
//   The stream drives the x_in/x_valid input of the next layer.
//   Sits between two layer instances in the top-level network; it is the producer end
//   of the serial layer-input protocol that each layer consumes.
//   Double-banked: the next frame is collected while the current frame is shifted out.
// PARAMETERS
//   NN         10  number of neurons (values per frame) in the upstream layer
//   dataWidth  16  width of one neuron output / one stream word
// PORTS
//   clk      in   1             clock; all logic on rising edge
//   rst      in   1             asynchronous, active-low reset
//   i_valid  in   NN            per-neuron result valid pulse (upstream o_valid)
//   i_data   in   NN*dataWidth  neuron k result at [k*dataWidth +: dataWidth]
//   o_ready  in   1             downstream accept; tie 1 when driving a layer
//   o_valid  out  1             stream word valid (next-layer x_valid)
//   o_data   out  dataWidth     stream word (next-layer x_in)
//   o_index  out  $clog2(NN)    neuron index of the current o_data (width 1 if NN==1)
//   o_last   out  1             high with the word of index NN-1
//   busy     out  1             SHIFT state or any capture flag set
//   overflow out  1             sticky error: result lost or duplicated
// BEHAVIOUR
//   Reset (rst=0, async): outputs 0, capture flags cleared, state IDLE, index 0.
//   Capture bank: on i_valid[k], cap_data[k]<=i_data slice, cap_flag[k]<=1.
//     - Several bits in one cycle are all captured.
//     - i_valid[k] while cap_flag[k] already 1: the new value is dropped, the first value
//       is kept, and overflow<=1.
//   Transfer: fires when registered cap_flag==all-ones AND one of the following holds:
//     - the state is IDLE, or
//     - the current frame completes this cycle (o_valid&o_ready&o_last).
//     On transfer: shift bank <= cap_data, all flags cleared, state<=SHIFT, index<=0.
//     i_valid in the transfer cycle lands in the freshly cleared bank; no overflow.
//   Shift FSM: IDLE -> SHIFT on transfer.
//     - SHIFT: o_valid=1, o_data=shift_bank[o_index].
//     - On o_valid&o_ready: index++. At index NN-1 (o_last=1), go to IDLE or reload
//       via transfer.
//     - o_ready=0: o_data/o_index/o_last held stable, no word lost.
//   Latency: last missing i_valid bit at cycle t -> flags full at t+1 -> first word
//     (index 0) at t+2. Back-to-back frames have no bubble when o_ready=1.
//   NN==1: every word has o_last=1.
//   Overflow is cleared only by reset.
//   Reset mid-frame: o_valid drops immediately; the partial frame is discarded.
//   Widths: data passes through unmodified; no arithmetic on values.
// STRUCTURE
//   Shared package nn_pkg: default dataWidth, clog2-based index-width helper, state
//     enum {IDLE, SHIFT}.
//   One sub-module: layer_capture_bank, holding cap_data, cap_flag, the overflow
//     detect and the all-flags-set output.
//   This module holds the shift bank, the FSM and the output registers.
// TESTING
//   1. NN=10, all i_valid at cycle t, neuron k data=k+1, o_ready=1
//      -> o_valid on cycles t+2..t+11, o_data 1..10, o_index 0..9, o_last only on 10.
//   2. i_valid bits pulsed one per cycle in order 9..0
//      -> first word 2 cycles after bit 0; output order still index 0..9; overflow=0.
//   3. o_ready pattern 1,0 repeating during a frame
//      -> 10 words over 20 cycles; each word held while stalled; values 1..10 exact.
//   4. Second frame (data 11..20) completes while the first is shifting
//      -> word 11 on the cycle after word 10; no gap; busy=0 after word 20.
//   5. i_valid[3] pulsed twice before the frame completes (values 0x00AA then 0x00BB)
//      -> overflow=1 and stays 1; index 3 emits 0x00AA.
//   6. rst=0 asserted while o_index=4
//      -> o_valid=0 and busy=0 without a clock edge; after release, IDLE and no
//         output until a new full frame arrives.

Source files
------------

// File: rtl/layer_output_serializer_pkg.sv
// Shared types and helpers for the layer output serializer.
package layer_output_serializer_pkg;

    localparam int NN_DEF         = 10;
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Index width for an n-entry frame; a single-neuron layer still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_output_serializer_if.sv
// Serial layer-input stream: one word per cycle with valid/ready handshake.
interface layer_output_serializer_if
    import layer_output_serializer_pkg::*;
#(
    parameter int NN        = NN_DEF,
    parameter int dataWidth = DATA_WIDTH_DEF
);
    localparam int IW = idx_width(NN);

    logic                 o_valid;
    logic                 o_ready;
    logic [dataWidth-1:0] o_data;
    logic [IW-1:0]        o_index;
    logic                 o_last;

    modport master (
        output o_valid,
        output o_data,
        output o_index,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid,
        input  o_data,
        input  o_index,
        input  o_last,
        output o_ready
    );

endinterface

// File: rtl/layer_output_serializer_capture_bank.sv
// Collection bank for one frame of neuron results. Each neuron owns one slot;
// the first value that arrives in a slot wins, and a second arrival before the
// bank is handed over raises the sticky overflow flag.
module layer_capture_bank
    import layer_output_serializer_pkg::*;
#(
    parameter int NN        = NN_DEF,
    parameter int dataWidth = DATA_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NN-1:0]                    i_valid,
    input  logic [NN*dataWidth-1:0]          i_data,
    input  logic                             clear,
    output logic [NN-1:0][dataWidth-1:0]     cap_data,
    output logic                             all_set,
    output logic                             any_set,
    output logic                             overflow
);

    logic [NN-1:0] cap_flag;

    // Capture arriving results; a clear empties the bank in the same cycle so
    // results arriving alongside it start the next frame instead of colliding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_flag <= '0;
            cap_data <= '0;
            overflow <= 1'b0;
        end else begin
            for (int k = 0; k < NN; k++) begin
                if (i_valid[k]) begin
                    if (cap_flag[k] && !clear) begin
                        overflow <= 1'b1;
                    end else begin
                        cap_data[k] <= i_data[k*dataWidth +: dataWidth];
                    end
                end
            end
            cap_flag <= (clear ? '0 : cap_flag) | i_valid;
        end
    end

    assign all_set = &cap_flag;
    assign any_set = |cap_flag;

endmodule

// File: rtl/layer_output_serializer.sv
// Turns one layer's parallel neuron results into a serial stream for the next
// layer. A full capture bank is copied into the shift bank either when the
// shifter is idle or on the very cycle its last word is accepted, so
// back-to-back frames stream without a bubble.
module layer_output_serializer
    import layer_output_serializer_pkg::*;
#(
    parameter int NN        = NN_DEF,
    parameter int dataWidth = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NN-1:0]                 i_valid,
    input  logic [NN*dataWidth-1:0]       i_data,
    layer_output_serializer_if.master     stream,
    output logic                          busy,
    output logic                          overflow
);

    localparam int            IW       = idx_width(NN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    logic [NN-1:0][dataWidth-1:0] cap_data;
    logic [NN-1:0][dataWidth-1:0] shift_bank;
    logic                         all_set;
    logic                         any_set;
    logic                         transfer;
    logic                         fire;
    logic                         last_fire;
    logic [IW-1:0]                next_idx;

    state_t               state;
    logic                 valid_q;
    logic [dataWidth-1:0] data_q;
    logic [IW-1:0]        idx_q;
    logic                 last_q;

    layer_capture_bank #(
        .NN        (NN),
        .dataWidth (dataWidth)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .clear    (transfer),
        .cap_data (cap_data),
        .all_set  (all_set),
        .any_set  (any_set),
        .overflow (overflow)
    );

    assign fire      = valid_q & stream.o_ready;
    assign last_fire = fire & last_q;
    assign transfer  = all_set & ((state == IDLE) | last_fire);
    assign next_idx  = idx_q + 1'b1;

    // Shift FSM with registered stream outputs; a stalled word simply holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_bank <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
        end else if (transfer) begin
            shift_bank <= cap_data;
            state      <= SHIFT;
            valid_q    <= 1'b1;
            data_q     <= cap_data[0];
            idx_q      <= '0;
            last_q     <= (NN == 1);
        end else if (last_fire) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else if (fire) begin
            idx_q  <= next_idx;
            data_q <= shift_bank[next_idx];
            last_q <= (next_idx == LAST_IDX);
        end
    end

    assign stream.o_valid = valid_q;
    assign stream.o_data  = data_q;
    assign stream.o_index = idx_q;
    assign stream.o_last  = last_q;

    assign busy = (state == SHIFT) | any_set;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Randomized and directed bench for layer_output_serializer with a queue-based
// reference: completed frames become a queue of expected stream words.
module tb_layer_output_serializer;
    import layer_output_serializer_pkg::*;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int IW = idx_width(NN);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NN-1:0]     i_valid = '0;
    logic [NN*DW-1:0]  i_data = '0;
    logic              rdy = 1'b1;
    logic              busy;
    logic              overflow;

    layer_output_serializer_if #(.NN(NN), .dataWidth(DW)) stream ();

    assign stream.o_ready = rdy;

    layer_output_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .stream   (stream),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: pending frame slots and the words still owed downstream.
    logic [DW-1:0] m_data [NN];
    bit            m_flag [NN];
    bit            m_ovf;
    logic [DW-1:0] wq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        wq.delete();
        m_ovf = 1'b0;
        for (int k = 0; k < NN; k++) begin
            m_flag[k] = 1'b0;
            m_data[k] = '0;
        end
    endtask

    // One clock edge of the reference: emit, hand over a full frame, then capture.
    task automatic model_step();
        int n;
        bit full;
        bit hs;
        bit xfer;
        n    = wq.size();
        full = 1'b1;
        for (int k = 0; k < NN; k++) if (!m_flag[k]) full = 1'b0;
        hs   = (n > 0) && rdy;
        xfer = full && ((n == 0) || (hs && n == 1));
        if (hs) void'(wq.pop_front());
        if (xfer) begin
            for (int k = 0; k < NN; k++) begin
                wq.push_back(m_data[k]);
                m_flag[k] = 1'b0;
            end
        end
        for (int k = 0; k < NN; k++) begin
            if (i_valid[k]) begin
                if (m_flag[k]) m_ovf = 1'b1;
                else begin
                    m_data[k] = i_data[k*DW +: DW];
                    m_flag[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int n;
        bit any;
        n   = wq.size();
        any = 1'b0;
        for (int k = 0; k < NN; k++) if (m_flag[k]) any = 1'b1;
        check_val("o_valid", 32'(stream.o_valid), 32'(n > 0));
        if (n > 0) begin
            check_val("o_data",  32'(stream.o_data),  32'(wq[0]));
            check_val("o_index", 32'(stream.o_index), 32'(NN - n));
            check_val("o_last",  32'(stream.o_last),  32'(n == 1));
        end
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("busy",     32'(busy),     32'((n > 0) || any));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check at the next fall.
    task automatic cycle(input logic [NN-1:0] v, input logic [NN*DW-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        rdy     = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1);
    endtask

    function automatic logic [NN*DW-1:0] seq_data(input int base);
        logic [NN*DW-1:0] d;
        d = '0;
        for (int k = 0; k < NN; k++) d[k*DW +: DW] = DW'(base + k);
        return d;
    endfunction

    // Reset asserted between edges; outputs must drop without waiting for a clock.
    task automatic apply_reset();
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_o_valid",  32'(stream.o_valid), 32'd0);
        check_val("rst_busy",     32'(busy),           32'd0);
        check_val("rst_overflow", 32'(overflow),       32'd0);
        model_clear();
        i_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        compare_all();
    endtask

    initial begin
        logic [NN*DW-1:0] d;
        logic [NN-1:0]    v;
        bit               reached;

        model_clear();
        @(negedge clk);
        apply_reset();

        // Frame with data k+1; first word two edges after the capture edge.
        cycle('1, seq_data(1), 1'b1);
        check_val("t1_not_yet", 32'(stream.o_valid), 32'd0);
        cycle('0, '0, 1'b1);
        check_val("t1_first_data",  32'(stream.o_data),  32'd1);
        check_val("t1_first_index", 32'(stream.o_index), 32'd0);
        idle(12);

        // Bits arrive one per cycle from 9 down to 0.
        for (int b = NN - 1; b >= 0; b--) cycle(NN'(1) << b, seq_data(1), 1'b1);
        idle(13);

        // Downstream accepts every other cycle.
        cycle('1, seq_data(1), 1'b1);
        for (int i = 0; i < 24; i++) cycle('0, '0, (i % 2) == 0);
        idle(3);

        // Second frame captured while the first shifts: no gap between them.
        cycle('1, seq_data(1), 1'b1);
        idle(3);
        cycle('1, seq_data(11), 1'b1);
        idle(22);
        check_val("t4_busy_end", 32'(busy), 32'd0);

        // Duplicate result on neuron 3: first value kept, overflow sticks.
        d = '0;
        d[3*DW +: DW] = 16'h00AA;
        cycle(NN'(1) << 3, d, 1'b1);
        d[3*DW +: DW] = 16'h00BB;
        cycle(NN'(1) << 3, d, 1'b1);
        v = '1;
        v[3] = 1'b0;
        cycle(v, seq_data(1), 1'b1);
        cycle('0, '0, 1'b1);
        check_val("t5_idx3_pending", 32'(stream.o_valid), 32'd1);
        idle(14);
        check_val("t5_overflow_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a frame.
        apply_reset();
        cycle('1, seq_data(1), 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (stream.o_valid && stream.o_index == IW'(4)) reached = 1'b1;
            else cycle('0, '0, 1'b1);
        end
        check_val("t6_reach_idx4", 32'(reached), 32'd1);
        apply_reset();
        idle(6);
        v = '0;
        v[4:0] = '1;
        cycle(v, seq_data(40), 1'b1);
        idle(6);
        v = '1;
        v[4:0] = '0;
        cycle(v, seq_data(40), 1'b1);
        idle(13);

        // Random traffic: sparse result pulses, occasional full frames, random stalls.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NN; k++) begin
                v[k] = ($urandom_range(0, 7) == 0);
                d[k*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(0, 29) == 0) v = '1;
            cycle(v, d, $urandom_range(0, 3) != 0);
        end
        idle(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
